// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared constants and types for the SHA-256 message schedule
package sha256_pkg;
  localparam int WORD_WIDTH  = 32;
  localparam int NUM_WORDS   = 64;
  localparam int BLOCK_WIDTH = 512;
  localparam int WIN_DEPTH   = 16;

  typedef logic [WORD_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;
endpackage

// File: rtl/sha256_sched_sigma.sv
// rtl/sha256_sched_sigma.sv - combinational SHA-256 small sigma functions
module sha256_sched_sigma
  import sha256_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] x0,
  input  logic [WORD_WIDTH-1:0] x1,
  output logic [WORD_WIDTH-1:0] s0,
  output logic [WORD_WIDTH-1:0] s1
);

  // sigma0 = ROTR7 ^ ROTR18 ^ SHR3, sigma1 = ROTR17 ^ ROTR19 ^ SHR10
  assign s0 = {x0[6:0], x0[31:7]} ^ {x0[17:0], x0[31:18]} ^ (x0 >> 3);
  assign s1 = {x1[16:0], x1[31:17]} ^ {x1[18:0], x1[31:19]} ^ (x1 >> 10);

endmodule

// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - expands a padded 512-bit block into W[0..63]
// using a 16-word sliding window, one word per accepted handshake.
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   go_sig,
  input  logic [BLOCK_WIDTH-1:0] pad_mem,
  input  logic                   w_ready,
  output logic                   w_valid,
  output logic [WORD_WIDTH-1:0]  w_data,
  output logic [5:0]             w_index,
  output logic                   busy,
  output logic                   sched_done
);

  state_t state, next_state;
  word_t  window [WIN_DEPTH];
  logic [5:0] t;
  logic   xfer;
  logic   last_xfer;
  word_t  sig0, sig1, feedback;

  sha256_sched_sigma u_sigma (
    .x0 (window[1]),
    .x1 (window[14]),
    .s0 (sig0),
    .s1 (sig1)
  );

  // W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t], mod 2^32
  assign feedback = sig1 + window[9] + sig0 + window[0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    xfer       = 1'b0;
    last_xfer  = 1'b0;
    case (state)
      IDLE: begin
        if (go_sig) next_state = RUN;
      end
      RUN: begin
        xfer      = w_ready;
        last_xfer = w_ready && (t == 6'(NUM_WORDS - 1));
        if (last_xfer) next_state = DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      window <= '{default: '0};
      t      <= '0;
    end else if (state == IDLE && go_sig) begin
      for (int i = 0; i < WIN_DEPTH; i++) begin
        window[i] <= pad_mem[BLOCK_WIDTH-1-WORD_WIDTH*i -: WORD_WIDTH];
      end
      t <= '0;
    end else if (xfer) begin
      for (int i = 0; i < WIN_DEPTH - 1; i++) begin
        window[i] <= window[i+1];
      end
      window[WIN_DEPTH-1] <= feedback;
      // clear explicitly so t never wraps through 63
      t <= last_xfer ? 6'd0 : t + 6'd1;
    end
  end

  assign w_valid    = (state == RUN);
  assign busy       = (state == RUN);
  assign sched_done = (state == DONE);
  assign w_data     = (state == RUN) ? window[0] : '0;
  assign w_index    = t;

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
Downstream neighbour of gen_pad_msg. Captures the 512-bit padded block when pad_msg_rdy/go is asserted and expands it into the 64-word SHA-256 message schedule W[0..63]. Streams one 32-bit word per accepted handshake to the compression-round core. Uses a 16-word sliding window, so no 64-entry storage is needed.

Parameters:
WORD_WIDTH, 32, schedule word width; fixed by SHA-256, not for retuning.
NUM_WORDS, 64, number of schedule words produced per block.
BLOCK_WIDTH, 512, padded block width (16 x WORD_WIDTH).

Ports:
clock  input  1  rising-edge system clock
reset  input  1  asynchronous, active-high reset
go_sig  input  1  start pulse; driven by gen_pad_msg pad_msg_rdy
pad_mem  input  BLOCK_WIDTH  padded block; word 0 = bits [511:480], big-endian
w_ready  input  1  consumer ready to take the current word
w_valid  output  1  w_data/w_index are valid
w_data  output  WORD_WIDTH  current schedule word W[t]
w_index  output  6  current t (0..63)
busy  output  1  block captured, schedule not yet fully delivered
sched_done  output  1  one-cycle pulse after W[63] is accepted

Behaviour:
- Reset, asynchronous, takes effect mid-operation too. State = IDLE. w_valid=0, w_data=0, w_index=0, busy=0, sched_done=0. Window cleared to 0.
- States: IDLE, RUN, DONE.
- IDLE: go_sig=1 loads window[i] = pad_mem[511-32i -: 32] for i=0..15 and sets t=0 -> RUN. go_sig=0 stays in IDLE.
- Latency: go_sig sampled high on edge N; w_valid=1 with W[0] from edge N onward (visible in cycle N+1).
- RUN:
  - w_valid=1, busy=1, w_data=window[0], w_index=t.
  - Transfer occurs on an edge where w_valid && w_ready.
  - On a transfer: window shifts down one place (window[i] <= window[i+1]), t <= t+1.
  - window[15] <= sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0], modulo 2^32 (carries discarded).
- Sigma functions:
  - sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- Words 0..15 are therefore the block words unchanged, and words 16..63 are the expansions. The feedback term is computed every transfer. Words appended after t=48 are never output; this is harmless.
- w_ready=0 in RUN: hold window, t and outputs stable. There is no limit on stall length.
- Transfer with t=63: go to DONE. w_valid <= 0.
- DONE: sched_done=1 for exactly one cycle, busy=0, then go to IDLE. go_sig during DONE is ignored.
- go_sig while in RUN or DONE is ignored, and pad_mem is not re-sampled. pad_mem is only sampled on the IDLE start edge; it may change freely afterwards.
- Minimum block time with w_ready tied high: 64 transfer cycles + 1 DONE cycle. The next go_sig is accepted in the cycle after the sched_done pulse.
- t is 6 bits; the DONE transition prevents it wrapping past 63.

Decomposition:
- Shared package sha256_pkg:
  - constants WORD_WIDTH=32, NUM_WORDS=64, BLOCK_WIDTH=512, WIN_DEPTH=16;
  - state enum (IDLE, RUN, DONE);
  - typedef word_t.
- One natural sub-module, sha256_sched_sigma: purely combinational, inputs x0 and x1, outputs sigma0(x0) and sigma1(x1). The compression core can reuse it for its own functions.

Test Plan:
1. "abc" block (pad_mem = 0x61626380, 13 zero words, 0x00000000, 0x00000018), go pulse, w_ready=1 -> w_valid rises one edge after go. Required words: W0=0x61626380, W1..W14=0, W15=0x00000018, W16=0x61626380, W17=0x000F0000, W18=0x7DA86405. Exactly 64 transfers, w_index 0..63 in order, one sched_done pulse.
2. All-zero block -> all 64 words = 0x00000000; sched_done after 64 cycles.
3. w_ready toggled pseudo-randomly during the "abc" run -> the word sequence is identical to scenario 1. w_data and w_index hold stable on every cycle where w_ready=0.
4. go_sig re-pulsed at t=20 with a different pad_mem -> ignored; the output sequence is unchanged.
5. reset asserted asynchronously (mid-cycle) at t=30 -> w_valid, busy and w_index go to 0 immediately. A fresh go_sig then restarts from W0.
6. Back-to-back blocks: go_sig in the cycle after sched_done -> the second block starts cleanly, and its W0 equals the second pad_mem[511:480].
